// File: rtl/operand_stack.sv
// Operand stack for decode: one push plus multi-entry pop per cycle, two tops presented combinationally.
// Latency: 1 cycle from operation to updated tops/depth/flags; no back-pressure, the writeback producer owns legality.
// OPSTACK_GUARD_EN: drop illegal operations whole and raise sticky st__err; otherwise clamp underflow and drop overflow pushes.
module operand_stack #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 64,
    parameter int POP_W = 11,
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               st__push,
    input  logic [WIDTH-1:0]   st__to_push,
    input  logic [POP_W-1:0]   st__to_pop,
    output logic [WIDTH-1:0]   st__top_0,
    output logic [WIDTH-1:0]   st__top_1,
    output logic [DEPTH_W-1:0] st__depth,
    output logic               st__empty,
    output logic               st__full,
    output logic               st__err
);
    localparam int AW = ((POP_W > DEPTH_W) ? POP_W : DEPTH_W) + 1;
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_W-1:0] d;
    logic [DEPTH_W-1:0] d_next;
    logic [AW-1:0]      d_ext;
    logic [AW-1:0]      p_ext;
    logic [AW-1:0]      base;
    logic [AW-1:0]      sum;
    logic               underflow;
    logic               overflow;
    logic               wr_en;
    logic [IW-1:0]      wr_idx;
    logic [IW-1:0]      idx_0;
    logic [IW-1:0]      idx_1;

    // Wide enough that a huge pop count compares as underflow instead of wrapping.
    always_comb begin
        d_ext     = AW'(d);
        p_ext     = AW'(st__to_pop);
        underflow = p_ext > d_ext;
        base      = d_ext - p_ext;
        sum       = base + AW'(st__push);
        overflow  = !underflow && (sum > AW'(DEPTH));
`ifdef OPSTACK_GUARD_EN
        wr_en  = st__push && !underflow && !overflow;
        wr_idx = IW'(base);
        d_next = (underflow || overflow) ? d : DEPTH_W'(sum);
`else
        wr_en  = st__push && !overflow;
        wr_idx = underflow ? '0 : IW'(base);
        if (underflow) begin
            d_next = DEPTH_W'(st__push);
        end else if (overflow) begin
            d_next = DEPTH_W'(base);
        end else begin
            d_next = DEPTH_W'(sum);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            d <= '0;
        end else begin
            d <= d_next;
        end
    end

    // Storage is deliberately left unreset; entries at or above d are never observable.
    always_ff @(posedge clk) begin
        if (rst_b && wr_en) begin
            mem[wr_idx] <= st__to_push;
        end
    end

`ifdef OPSTACK_GUARD_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            err_q <= 1'b0;
        end else if (underflow || overflow) begin
            err_q <= 1'b1;
        end
    end

    assign st__err = err_q;
`else
    assign st__err = 1'b0;
`endif

    assign idx_0     = IW'(d - DEPTH_W'(1));
    assign idx_1     = IW'(d - DEPTH_W'(2));
    assign st__top_0 = (d >= DEPTH_W'(1)) ? mem[idx_0] : '0;
    assign st__top_1 = (d >= DEPTH_W'(2)) ? mem[idx_1] : '0;
    assign st__depth = d;
    assign st__empty = (d == '0);
    assign st__full  = (d == DEPTH_W'(DEPTH));

endmodule
